approx_mul_eval_ctrl: RTL

Hardware error-characterisation sequencer for the 8-bit approximate Dadda multiplier (dadda_8bit_cmp4 or any drop-in variant).
- Drives operand pairs into the externally instantiated combinational multiplier and waits a programmable settle time.
- Compares each result against an internally computed exact product and accumulates error statistics (error count, sum of |ED|, max |ED|).
- Replaces software-side metric collection for on-chip/FPGA evaluation runs. Supports exhaustive sweep and LFSR-random sampling modes.

---
 rtl/approx_eval_pkg.sv | 27 ++
 rtl/approx_mul_eval_ctrl_lfsr16.sv | 41 ++++
 rtl/approx_mul_eval_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/approx_eval_pkg.sv
// Shared types and constants for the approximate-multiplier error
// characterisation sequencer and its LFSR helper.
package approx_eval_pkg;

    localparam int OPW  = 8;
    localparam int PW   = 16;
    localparam int SUMW = 33;
    localparam int CNTW = 17;

    localparam logic [15:0]     LFSR_TAPS   = 16'hB400;
    localparam logic [15:0]     DEF_SEED    = 16'hACE1;
    localparam logic [CNTW-1:0] EXH_SAMPLES = 17'd65536;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        ACC,
        DONE
    } state_t;

    // Absolute difference of two products, always non-negative.
    function automatic logic [PW-1:0] absDiff(input logic [PW-1:0] a, input logic [PW-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/approx_mul_eval_ctrl_lfsr16.sv
// 16-bit right-shifting Galois LFSR used to generate random operand pairs.
// A zero seed would lock the register at zero, so the controller always
// supplies a non-zero seed and the reset value is non-zero as well.
module lfsr16
    import approx_eval_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = approx_eval_pkg::DEF_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next state of one Galois step: shift right, fold the taps in when a one falls out.
    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) begin
            lfsr_d = (lfsr_q >> 1) ^ LFSR_TAPS;
        end
    end

    // Loading a new seed takes priority over stepping.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= RESET_VAL;
        end else if (load) begin
            lfsr_q <= seed;
        end else if (step) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/approx_mul_eval_ctrl.sv
// Error-characterisation sequencer for an external 8x8 approximate
// multiplier. Each sample: LOAD drives the operands, WAIT lets the
// combinational multiplier settle, ACC compares against the exact product
// and accumulates error count, sum of |ED| and max |ED|.
module approx_mul_eval_ctrl
    import approx_eval_pkg::*;
#(
    parameter int          W        = 8,
    parameter int          SETTLE   = 4,
    parameter logic [15:0] DEF_SEED = approx_eval_pkg::DEF_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [CNTW-1:0]   num_samples,
    input  logic [15:0]       seed,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic [2*W-1:0]    mul_o,
    output logic              busy,
    output logic              done,
    output logic [CNTW-1:0]   samples_done,
    output logic [CNTW-1:0]   err_count,
    output logic [SUMW-1:0]   sum_ed_abs,
    output logic [2*W-1:0]    max_ed
);

    // A settle counter of at least one bit keeps SETTLE=1 legal.
    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE - 1);

    state_t            state_q;
    logic              mode_q;
    logic [CNTW-1:0]   target_q;
    logic [CNTW-1:0]   sweepCnt_q;
    logic [SCW-1:0]    settleCnt_q;
    logic [W-1:0]      mulA_q;
    logic [W-1:0]      mulB_q;
    logic              busy_q;
    logic              done_q;
    logic [CNTW-1:0]   samplesDone_q;
    logic [CNTW-1:0]   errCount_q;
    logic [SUMW-1:0]   sumEdAbs_q;
    logic [PW-1:0]     maxEd_q;

    logic [PW-1:0]     exactProd;
    logic [PW-1:0]     edAbs;
    logic [CNTW-1:0]   samplesDone_d;
    logic [CNTW-1:0]   errCount_d;
    logic [SUMW-1:0]   sumEdAbs_d;
    logic [PW-1:0]     maxEd_d;

    logic              startAccept;
    logic [15:0]       seedEff;
    logic              lfsrStep;
    logic [15:0]       lfsrQ;

    // A start is only honoured when the sequencer is idle or finished.
    always_comb begin
        startAccept = start && ((state_q == IDLE) || (state_q == DONE));
        seedEff     = (seed == 16'd0) ? DEF_SEED : seed;
        lfsrStep    = (state_q == ACC) && mode_q;
    end

    lfsr16 #(
        .RESET_VAL (DEF_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (startAccept),
        .seed (seedEff),
        .step (lfsrStep),
        .q    (lfsrQ)
    );

    // Error distance of the current sample and the accumulator values it would produce.
    always_comb begin
        exactProd     = PW'(mulA_q) * PW'(mulB_q);
        edAbs         = absDiff(exactProd, PW'(mul_o));
        samplesDone_d = samplesDone_q + CNTW'(1);
        errCount_d    = errCount_q + ((edAbs != '0) ? CNTW'(1) : CNTW'(0));
        sumEdAbs_d    = sumEdAbs_q + SUMW'(edAbs);
        maxEd_d       = (edAbs > maxEd_q) ? edAbs : maxEd_q;
    end

    // Main sequencer: owns all registered outputs and the per-sample LOAD/WAIT/ACC loop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mode_q        <= 1'b0;
            target_q      <= '0;
            sweepCnt_q    <= '0;
            settleCnt_q   <= '0;
            mulA_q        <= '0;
            mulB_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            samplesDone_q <= '0;
            errCount_q    <= '0;
            sumEdAbs_q    <= '0;
            maxEd_q       <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        samplesDone_q <= '0;
                        errCount_q    <= '0;
                        sumEdAbs_q    <= '0;
                        maxEd_q       <= '0;
                        sweepCnt_q    <= '0;
                        mode_q        <= mode;
                        target_q      <= mode ? num_samples : EXH_SAMPLES;
                        if (mode && (num_samples == '0)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= LOAD;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (mode_q) begin
                        mulA_q <= lfsrQ[15:8];
                        mulB_q <= lfsrQ[7:0];
                    end else begin
                        mulA_q <= sweepCnt_q[15:8];
                        mulB_q <= sweepCnt_q[7:0];
                    end
                    settleCnt_q <= '0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (settleCnt_q == SETTLE_LAST) begin
                        state_q <= ACC;
                    end else begin
                        settleCnt_q <= settleCnt_q + SCW'(1);
                    end
                end
                ACC: begin
                    samplesDone_q <= samplesDone_d;
                    errCount_q    <= errCount_d;
                    sumEdAbs_q    <= sumEdAbs_d;
                    maxEd_q       <= maxEd_d;
                    sweepCnt_q    <= sweepCnt_q + CNTW'(1);
                    if (samplesDone_d == target_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= LOAD;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mul_a        = mulA_q;
    assign mul_b        = mulB_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign samples_done = samplesDone_q;
    assign err_count    = errCount_q;
    assign sum_ed_abs   = sumEdAbs_q;
    assign max_ed       = maxEd_q;

endmodule
